// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline freeze/flush/bubble sequencer for PC, IF/ID, ID/EX, EX/MEM
// Optional perf counters stall_cycles/flush_events when HAZARD_PERF_EN is defined.
module pipe_hazard_ctrl #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int FLUSH_EXTRA  = 1
`ifdef HAZARD_PERF_EN
  , parameter int PERF_W     = 16
`endif
) (
  input  logic       clk_IDEX,
  input  logic       rst_IDEX,
  input  logic [4:0] Rs1_addr_ID,
  input  logic [4:0] Rs2_addr_ID,
  input  logic       Rs1_used_ID,
  input  logic       Rs2_used_ID,
  input  logic [4:0] Rd_addr_EX,
  input  logic [1:0] MemtoReg_EX,
  input  logic       RegWrite_EX,
  input  logic       Branch_taken_EX,
  input  logic       Jump_EX,
  input  logic       mem_req_MEM,
  input  logic       mem_ready_MEM,
  output logic       en_PC,
  output logic       en_IFID,
  output logic       flush_IFID,
  output logic       en_IDEX,
  output logic       flush_IDEX,
  output logic       en_EXMEM,
  output logic       mem_timeout,
  output logic [1:0] ctrl_state
`ifdef HAZARD_PERF_EN
  , output logic [PERF_W-1:0] stall_cycles
  , output logic [PERF_W-1:0] flush_events
`endif
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_FLUSH    = 2'd2
  } state_t;

  localparam logic [7:0] WAIT_MAX   = 8'(MEM_WAIT_MAX);
  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_EXTRA);

  state_t     state, next_state;
  logic [7:0] wait_cnt, next_wait_cnt;
  logic [1:0] flush_cnt, next_flush_cnt;

  logic memstall, redirect, loaduse, wait_abort;

  assign memstall = mem_req_MEM & ~mem_ready_MEM;
  assign redirect = Branch_taken_EX | Jump_EX;
  assign loaduse  = (MemtoReg_EX == 2'b01) && RegWrite_EX && (Rd_addr_EX != 5'd0) &&
                    ((Rs1_used_ID && (Rs1_addr_ID == Rd_addr_EX)) ||
                     (Rs2_used_ID && (Rs2_addr_ID == Rd_addr_EX)));
  assign wait_abort = memstall && (state == S_MEM_WAIT) && (wait_cnt == WAIT_MAX);

  always_ff @(negedge clk_IDEX or posedge rst_IDEX) begin
    if (rst_IDEX) begin
      state     <= S_RUN;
      wait_cnt  <= 8'd0;
      flush_cnt <= 2'd0;
    end else begin
      state     <= next_state;
      wait_cnt  <= next_wait_cnt;
      flush_cnt <= next_flush_cnt;
    end
  end

  always_comb begin
    next_state     = state;
    next_wait_cnt  = wait_cnt;
    next_flush_cnt = flush_cnt;
    en_PC          = 1'b1;
    en_IFID        = 1'b1;
    en_IDEX        = 1'b1;
    en_EXMEM       = 1'b1;
    flush_IFID     = 1'b0;
    flush_IDEX     = 1'b0;
    mem_timeout    = 1'b0;

    if (wait_abort) begin
      mem_timeout   = 1'b1;
      next_state    = S_RUN;
      next_wait_cnt = 8'd0;
    end else if (memstall) begin
      // Full freeze; a pending redirect waits in EX until the stall clears.
      en_PC    = 1'b0;
      en_IFID  = 1'b0;
      en_IDEX  = 1'b0;
      en_EXMEM = 1'b0;
      if (state == S_MEM_WAIT) begin
        next_wait_cnt = wait_cnt + 8'd1;
      end else if (state != S_FLUSH) begin
        next_state    = S_MEM_WAIT;
        next_wait_cnt = 8'd1;
      end
    end else if (state == S_FLUSH) begin
      flush_IFID = 1'b1;
      flush_IDEX = redirect | loaduse;
      if (redirect) begin
        next_flush_cnt = FLUSH_LOAD;
      end else begin
        next_flush_cnt = flush_cnt - 2'd1;
        if (flush_cnt == 2'd1) next_state = S_RUN;
      end
    end else begin
      next_state    = S_RUN;
      next_wait_cnt = 8'd0;
      if (redirect) begin
        flush_IFID = 1'b1;
        flush_IDEX = 1'b1;
        if (FLUSH_LOAD != 2'd0) begin
          next_state     = S_FLUSH;
          next_flush_cnt = FLUSH_LOAD;
        end
      end else if (loaduse) begin
        en_PC      = 1'b0;
        en_IFID    = 1'b0;
        flush_IDEX = 1'b1;
      end
    end

    if (rst_IDEX) begin
      en_PC       = 1'b0;
      en_IFID     = 1'b0;
      en_IDEX     = 1'b0;
      en_EXMEM    = 1'b0;
      flush_IFID  = 1'b1;
      flush_IDEX  = 1'b1;
      mem_timeout = 1'b0;
    end
  end

  assign ctrl_state = state;

`ifdef HAZARD_PERF_EN
  logic redirect_serviced;
  assign redirect_serviced = redirect & ~memstall;

  always_ff @(negedge clk_IDEX or posedge rst_IDEX) begin
    if (rst_IDEX) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (!en_PC && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
      if (redirect_serviced && (flush_events != '1)) flush_events <= flush_events + 1'b1;
    end
  end
`endif

endmodule
